// File: rtl/defines_pkg.sv
// rtl/defines_pkg.sv - unit ids, result-ready stages and tag entry type for the forwarding scoreboard
package defines_pkg;

  localparam int ADDR_W = 7;
  localparam int RDY_W  = 4;

  typedef enum logic [2:0] {
    SP_FX     = 3'd0,
    SIMPLE_FX = 3'd1,
    BYTE      = 3'd2,
    PERM      = 3'd3,
    LS        = 3'd4,
    FP        = 3'd5,
    BRANCH    = 3'd6
  } unit_e;

  // First stage at which each unit's result may be forwarded; id 7 has no unit and is out of range.
  localparam logic [RDY_W-1:0] RDY_STAGE [8] = '{
    4'd2, 4'd2, 4'd4, 4'd4, 4'd6, 4'd7, 4'd1, 4'd15
  };

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [RDY_W-1:0]  rdy_stage;
  } tag_t;

endpackage

// File: rtl/fw_tag_pipe.sv
// rtl/fw_tag_pipe.sv - one pipe's in-flight destination tags, shifting one stage per clock
module fw_tag_pipe
  import defines_pkg::*;
#(
  parameter int DEPTH        = 7,
  parameter int FLUSH_STAGES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_vld,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [RDY_W-1:0]    load_rdy,
  input  logic                flush,
  output tag_t [DEPTH:1]      tags
);

  tag_t [DEPTH:1] tags_q;
  tag_t [DEPTH:1] tags_d;

  // Entries sitting in the youngest FLUSH_STAGES stages at a flush belong to the wrong path.
  always_comb begin
    tags_d    = tags_q;
    tags_d[1] = '{vld: load_vld & ~flush, addr: load_addr, rdy_stage: load_rdy};
    for (int s = 2; s <= DEPTH; s++) begin
      tags_d[s] = tags_q[s-1];
      if (flush && ((s - 1) <= FLUSH_STAGES)) begin
        tags_d[s].vld = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tags_q <= '0;
    end else begin
      tags_q <= tags_d;
    end
  end

  assign tags = tags_q;

  ap_rdy_range: assert property (@(posedge clk) disable iff (!rst)
    (load_vld && !flush) |-> (int'(load_rdy) <= DEPTH));

endmodule

// File: rtl/fw_scoreboard.sv
// rtl/fw_scoreboard.sv - operand forwarding and hazard stall for the dual-issue SPU pipeline
module fw_scoreboard
  import defines_pkg::*;
#(
  parameter int NUM_PIPES    = 2,
  parameter int NUM_SRC      = 3,
  parameter int DEPTH        = 7,
  parameter int ADDR_WD      = ADDR_W,
  parameter int DATA_WD      = 128,
  parameter int UNIT_WD      = 3,
  parameter int FLUSH_STAGES = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PIPES-1:0]                 iss_vld,
  input  logic [NUM_PIPES-1:0]                 iss_wr_en,
  input  logic [NUM_PIPES*ADDR_WD-1:0]         iss_rt_addr,
  input  logic [NUM_PIPES*UNIT_WD-1:0]         iss_unit,
  input  logic                                 flush,
  input  logic [NUM_PIPES*DEPTH*DATA_WD-1:0]   res_data,
  input  logic [NUM_PIPES*NUM_SRC*ADDR_WD-1:0] src_addr,
  input  logic [NUM_PIPES*NUM_SRC*DATA_WD-1:0] src_data,
  output logic [NUM_PIPES*NUM_SRC*DATA_WD-1:0] fw_data,
  output logic                                 stall,
  output logic [NUM_PIPES*NUM_SRC-1:0]         hit_vec
);

  tag_t [DEPTH:1] pipe_tags [NUM_PIPES];
  logic [NUM_PIPES*NUM_SRC-1:0] stall_vec;

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
    fw_tag_pipe #(
      .DEPTH        (DEPTH),
      .FLUSH_STAGES (FLUSH_STAGES)
    ) u_tag_pipe (
      .clk       (clk),
      .rst       (rst),
      .load_vld  (iss_vld[p] & iss_wr_en[p] & ~stall),
      .load_addr (iss_rt_addr[p*ADDR_WD +: ADDR_WD]),
      .load_rdy  (RDY_STAGE[iss_unit[p*UNIT_WD +: UNIT_WD]]),
      .flush     (flush),
      .tags      (pipe_tags[p])
    );
  end

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_dst
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      localparam int IDX = p*NUM_SRC + k;

      logic               found;
      logic               usable;
      int                 sel_p;
      int                 sel_s;
      logic               hit;
      logic               wait_res;
      logic [DATA_WD-1:0] data;

      // Scan oldest to youngest so the last match kept is the youngest producer.
      always_comb begin
        found  = 1'b0;
        usable = 1'b0;
        sel_p  = 0;
        sel_s  = 1;
        for (int s = DEPTH; s >= 1; s--) begin
          for (int q = 0; q < NUM_PIPES; q++) begin
            if (pipe_tags[q][s].vld &&
                (pipe_tags[q][s].addr == src_addr[IDX*ADDR_WD +: ADDR_WD])) begin
              found  = 1'b1;
              usable = (s >= int'(pipe_tags[q][s].rdy_stage));
              sel_p  = q;
              sel_s  = s;
            end
          end
        end
        hit      = found & usable;
        wait_res = found & ~usable;
        data     = hit ? res_data[(sel_p*DEPTH + sel_s - 1)*DATA_WD +: DATA_WD]
                       : src_data[IDX*DATA_WD +: DATA_WD];
      end

      assign fw_data[IDX*DATA_WD +: DATA_WD] = data;
      assign hit_vec[IDX]                    = hit;
      assign stall_vec[IDX]                  = wait_res;
    end
  end

  assign stall = |stall_vec;

endmodule

// File: tb/tb_fw_scoreboard.sv
// tb/tb_fw_scoreboard.sv - scoreboard bench for fw_scoreboard: directed hazards plus random traffic
module tb_fw_scoreboard;
  import defines_pkg::*;

  localparam int NP = 2;
  localparam int NS = 3;
  localparam int D  = 7;
  localparam int AW = 7;
  localparam int DW = 128;
  localparam int UW = 3;
  localparam int FS = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NP-1:0]       iss_vld;
  logic [NP-1:0]       iss_wr_en;
  logic [NP*AW-1:0]    iss_rt_addr;
  logic [NP*UW-1:0]    iss_unit;
  logic                flush;
  logic [NP*D*DW-1:0]  res_data;
  logic [NP*NS*AW-1:0] src_addr;
  logic [NP*NS*DW-1:0] src_data;
  logic [NP*NS*DW-1:0] fw_data;
  logic                stall;
  logic [NP*NS-1:0]    hit_vec;

  always #5 clk = ~clk;

  fw_scoreboard #(
    .NUM_PIPES(NP), .NUM_SRC(NS), .DEPTH(D), .ADDR_WD(AW),
    .DATA_WD(DW), .UNIT_WD(UW), .FLUSH_STAGES(FS)
  ) dut (
    .clk(clk), .rst(rst), .iss_vld(iss_vld), .iss_wr_en(iss_wr_en),
    .iss_rt_addr(iss_rt_addr), .iss_unit(iss_unit), .flush(flush),
    .res_data(res_data), .src_addr(src_addr), .src_data(src_data),
    .fw_data(fw_data), .stall(stall), .hit_vec(hit_vec)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  typedef struct { int pipe; int addr; int rdy; int age; } rec_t;
  typedef struct { logic [NP*NS*DW-1:0] fw; logic stall; logic [NP*NS-1:0] hit; } exp_t;

  rec_t recs[$];
  exp_t exp_q[$];
  int   rdy_tab [7] = '{2, 2, 4, 4, 6, 7, 1};

  logic [NP*NS*DW-1:0] cap_fw;
  logic                cap_stall;
  logic [NP*NS-1:0]    cap_hit;

  function automatic logic [DW-1:0] res_at(input int p, input int s);
    return res_data[(p*D + s - 1)*DW +: DW];
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.fw    = src_data;
    e.stall = 1'b0;
    e.hit   = '0;
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < NS; k++) begin
        int best;
        int a;
        best = -1;
        a    = int'(src_addr[(p*NS+k)*AW +: AW]);
        foreach (recs[i]) begin
          if (recs[i].addr == a) begin
            if (best < 0 || recs[i].age < recs[best].age ||
                (recs[i].age == recs[best].age && recs[i].pipe > recs[best].pipe))
              best = i;
          end
        end
        if (best >= 0) begin
          if (recs[best].age >= recs[best].rdy) begin
            e.hit[p*NS+k]            = 1'b1;
            e.fw[(p*NS+k)*DW +: DW]  = res_at(recs[best].pipe, recs[best].age);
          end else begin
            e.stall = 1'b1;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic model_advance(input logic stall_exp);
    rec_t nq[$];
    if (!rst) begin
      recs.delete();
      return;
    end
    foreach (recs[i]) begin
      rec_t r;
      r = recs[i];
      if (flush && r.age <= FS) continue;
      r.age++;
      if (r.age <= D) nq.push_back(r);
    end
    if (!flush && !stall_exp) begin
      for (int p = 0; p < NP; p++) begin
        if (iss_vld[p] && iss_wr_en[p])
          nq.push_back('{pipe: p, addr: int'(iss_rt_addr[p*AW +: AW]),
                         rdy: rdy_tab[int'(iss_unit[p*UW +: UW])], age: 1});
      end
    end
    recs = nq;
  endtask

  task automatic run_cycle(input string tag);
    exp_t g;
    exp_q.push_back(model_out());
    @(negedge clk);
    cap_fw    = fw_data;
    cap_stall = stall;
    cap_hit   = hit_vec;
    g = exp_q.pop_front();
    for (int i = 0; i < NP*NS; i++)
      check($sformatf("%s fw[%0d]", tag, i), cap_fw[i*DW +: DW], g.fw[i*DW +: DW]);
    check({tag, " stall"}, DW'(cap_stall), DW'(g.stall));
    check({tag, " hit_vec"}, DW'(cap_hit), DW'(g.hit));
    model_advance(g.stall);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_vld     = '0;
    iss_wr_en   = '0;
    iss_rt_addr = '0;
    iss_unit    = '0;
    flush       = 1'b0;
    for (int i = 0; i < NP*NS; i++) src_addr[i*AW +: AW] = 7'd127;
    for (int i = 0; i < NP*NS*4; i++) src_data[i*32 +: 32] = $urandom;
    for (int i = 0; i < NP*D*4; i++) res_data[i*32 +: 32] = $urandom;
  endtask

  task automatic issue(input int p, input int a, input unit_e u);
    iss_vld[p]              = 1'b1;
    iss_wr_en[p]            = 1'b1;
    iss_rt_addr[p*AW +: AW] = 7'(a);
    iss_unit[p*UW +: UW]    = u;
  endtask

  task automatic set_src(input int p, input int k, input int a);
    src_addr[(p*NS+k)*AW +: AW] = 7'(a);
  endtask

  task automatic set_res(input int p, input int s, input logic [DW-1:0] v);
    res_data[(p*D + s - 1)*DW +: DW] = v;
  endtask

  function automatic logic [DW-1:0] fw_at(input int p, input int k);
    return cap_fw[(p*NS+k)*DW +: DW];
  endfunction

  task automatic drain();
    for (int i = 0; i <= D; i++) begin
      idle();
      run_cycle("drain");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] sv;
    rst = 1'b0;
    idle();
    #1;
    for (int c = 0; c < 2; c++) begin
      idle();
      src_data[0 +: DW] = {4{32'hA5A5A5A5}};
      run_cycle("reset");
      check("reset fw00", fw_at(0, 0), {4{32'hA5A5A5A5}});
      check("reset stall", DW'(cap_stall), DW'(0));
      check("reset hit", DW'(cap_hit), DW'(0));
    end
    rst = 1'b1;

    idle(); issue(0, 5, SP_FX); run_cycle("fwd c0");
    idle(); run_cycle("fwd c1");
    idle(); set_src(1, 0, 5); set_res(0, 2, {4{32'h11111111}}); run_cycle("fwd c2");
    check("fwd data", fw_at(1, 0), {4{32'h11111111}});
    check("fwd hit", DW'(cap_hit[NS]), DW'(1));
    check("fwd stall", DW'(cap_stall), DW'(0));

    drain();
    idle(); issue(0, 9, FP); run_cycle("stl c0");
    for (int c = 1; c <= 6; c++) begin
      idle(); set_src(0, 0, 9);
      run_cycle($sformatf("stl c%0d", c));
      check($sformatf("stl stall c%0d", c), DW'(cap_stall), DW'(1));
    end
    idle(); set_src(0, 0, 9); set_res(0, 7, {4{32'h77777777}}); run_cycle("stl c7");
    check("stl release", DW'(cap_stall), DW'(0));
    check("stl data", fw_at(0, 0), {4{32'h77777777}});

    drain();
    idle(); issue(0, 3, SP_FX); run_cycle("yng c0");
    idle(); issue(1, 3, SP_FX); run_cycle("yng c1");
    idle(); run_cycle("yng c2");
    idle(); set_src(0, 1, 3); set_res(1, 2, {4{32'h22222222}}); set_res(0, 3, {4{32'h33333333}});
    run_cycle("yng c3");
    check("yng stage", fw_at(0, 1), {4{32'h22222222}});
    drain();
    idle(); issue(0, 3, SP_FX); issue(1, 3, SP_FX); run_cycle("tie c0");
    idle(); run_cycle("tie c1");
    idle(); set_src(0, 0, 3); set_res(0, 2, {4{32'hAAAAAAAA}}); set_res(1, 2, {4{32'hBBBBBBBB}});
    run_cycle("tie c2");
    check("tie pipe", fw_at(0, 0), {4{32'hBBBBBBBB}});

    drain();
    idle(); issue(0, 4, BYTE); run_cycle("fl c0");
    idle(); flush = 1'b1; run_cycle("fl c1");
    for (int c = 2; c <= 5; c++) begin
      idle(); set_src(0, 0, 4); sv = src_data[0 +: DW];
      run_cycle($sformatf("fl c%0d", c));
      check($sformatf("fl stall c%0d", c), DW'(cap_stall), DW'(0));
      check($sformatf("fl data c%0d", c), fw_at(0, 0), sv);
    end
    drain();
    idle(); issue(0, 6, SP_FX); run_cycle("fs c0");
    for (int c = 1; c <= 3; c++) begin idle(); run_cycle("fs idle"); end
    idle(); flush = 1'b1; run_cycle("fs c4");
    idle(); set_src(0, 0, 6); set_res(0, 5, {4{32'h66666666}}); run_cycle("fs c5");
    check("fs hit", DW'(cap_hit[0]), DW'(1));
    check("fs data", fw_at(0, 0), {4{32'h66666666}});

    drain();
    idle(); issue(0, 8, SP_FX); run_cycle("ret c0");
    for (int c = 1; c <= D; c++) begin
      idle(); set_src(0, 0, 8); run_cycle($sformatf("ret c%0d", c));
    end
    check("ret last hit", DW'(cap_hit[0]), DW'(1));
    idle(); set_src(0, 0, 8); sv = src_data[0 +: DW]; run_cycle("ret gone");
    check("ret gone hit", DW'(cap_hit[0]), DW'(0));
    check("ret gone data", fw_at(0, 0), sv);

    drain();
    idle(); issue(0, 2, SP_FX); run_cycle("mr c0");
    idle(); run_cycle("mr c1");
    idle(); set_src(0, 0, 2); sv = src_data[0 +: DW];
    #2;
    check("mr hit before", DW'(hit_vec[0]), DW'(1));
    rst = 1'b0;
    #1;
    check("mr hit after", DW'(hit_vec[0]), DW'(0));
    check("mr data after", fw_data[0 +: DW], sv);
    recs.delete();
    run_cycle("mr held");
    rst = 1'b1;
    idle(); set_src(0, 0, 2); run_cycle("mr after");

    repeat (300) begin
      idle();
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          iss_vld[p]              = 1'b1;
          iss_wr_en[p]            = ($urandom_range(0, 3) != 0);
          iss_rt_addr[p*AW +: AW] = 7'($urandom_range(0, 7));
          iss_unit[p*UW +: UW]    = 3'($urandom_range(0, 6));
        end
      end
      for (int i = 0; i < NP*NS; i++) src_addr[i*AW +: AW] = 7'($urandom_range(0, 9));
      flush = ($urandom_range(0, 15) == 0);
      run_cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fw_scoreboard.md
Name: fw_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the dual-issue SPU pipeline, covering any number of pipes, sources and stages.
- Keeps its own in-flight destination-tag pipeline per pipe: one entry per stage, fed from issue. Per-stage tag ports are not needed.
- Selects the youngest ready producer for every source operand.
- Raises a stall when the youngest producer's result is not yet computed.

Parameters:
NUM_PIPES, 2, issue pipes (pipe 0 = even, 1 = odd)
NUM_SRC, 3, source operands per pipe (ra, rb, rc)
DEPTH, 7, tag-pipe stages per pipe (stage DEPTH = writeback)
ADDR_WD, 7, register address width
DATA_WD, 128, register data width
UNIT_WD, 3, execution-unit id width
FLUSH_STAGES, 3, youngest stages cleared by flush

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
iss_vld  in  NUM_PIPES  instruction issued on pipe p this cycle
iss_wr_en  in  NUM_PIPES  issued instruction writes a register
iss_rt_addr  in  NUM_PIPES*ADDR_WD  destination address
iss_unit  in  NUM_PIPES*UNIT_WD  unit id; selects result-ready stage
flush  in  1  branch mispredict; clears young entries
res_data  in  NUM_PIPES*DEPTH*DATA_WD  result data held at each stage of each pipe
src_addr  in  NUM_PIPES*NUM_SRC*ADDR_WD  source addresses at operand fetch
src_data  in  NUM_PIPES*NUM_SRC*DATA_WD  register-file read data
fw_data  out  NUM_PIPES*NUM_SRC*DATA_WD  forwarded operands
stall  out  1  issue must hold
hit_vec  out  NUM_PIPES*NUM_SRC  debug: operand was forwarded

Behaviour:
- Tag entry per (pipe, stage s = 1..DEPTH): vld, addr, rdy_stage.
- Reset (rst=0, async): all vld=0.
  - stall=0, hit_vec=0.
  - fw_data = src_data, since outputs are combinational from cleared state.
- Every clk edge, all entries shift s → s+1 unconditionally; execution never stalls. The stage-DEPTH entry retires.
- Stage-1 load for pipe p:
  - vld = iss_vld[p] & iss_wr_en[p] & ~stall & ~flush.
  - addr = iss_rt_addr[p].
  - rdy_stage = RDY_STAGE[iss_unit[p]].
  - Issue at cycle N is visible at stage 1 in cycle N+1.
- Data at (p, s) is usable iff vld && s >= rdy_stage.
- Operand match for (p, s): vld && addr == src_addr.
- Priority (youngest first):
  - lower stage number wins;
  - at equal stage, higher pipe index wins (odd is younger within a packet);
  - no match selects src_data.
- Youngest match usable → fw_data = res_data[p][s], hit bit = 1.
- Youngest match not usable:
  - stall = 1 (OR over all pipes and sources);
  - fw_data = src_data, a don't-care while stalled;
  - older usable matches are never used instead.
- rdy_stage > DEPTH is illegal; an assertion fires. rdy_stage = 1 means the result is available the cycle after issue.
- Stage DEPTH covers the write-then-read gap. After retirement the register file is assumed to return the new value.
- flush: at the edge, clear vld in stages 1..FLUSH_STAGES of all pipes and block stage-1 load. Stages beyond FLUSH_STAGES shift normally.
- Flush and stall in the same cycle: flush wins and stall has no effect on state.
- Same-packet dependencies (pipe 1 source equal to pipe 0 destination in the same issue cycle) are not detected here; issue logic handles them.
- Reset asserted mid-operation clears all entries immediately; no partial retire.

Decomposition:
- defines_pkg gains:
  - unit-id enum: SP_FX, SIMPLE_FX, BYTE, PERM, LS, FP, BRANCH;
  - RDY_STAGE constant array indexed by unit id (2, 2, 4, 4, 6, 7, 1);
  - a typedef struct for the tag entry.
- Sub-module fw_tag_pipe: one pipe's shift register with flush. Instantiated NUM_PIPES times with a generate loop.
- Priority selection stays in the top level as a generate over (pipe, src).

Test Plan:
- Reset: rst=0 for 2 cycles, src_data[0][0]=0xA5.. → fw_data[0][0]=0xA5.., stall=0, hit_vec=0.
- Basic forward:
  - issue pipe0 rt=5, unit SP_FX (rdy 2) at cycle 0; cycle 2 pipe1 ra=5, res_data[0][2]=0x11.. → fw_data[1][0]=0x11.., hit=1, stall=0.
- Stall on not-ready:
  - issue pipe0 rt=9, unit FP (rdy 7); next cycle src ra=9 → stall=1 for cycles 1..6;
  - cycle 7: fw_data = res_data[0][7], stall=0.
- Youngest wins:
  - rt=3 via pipe0 (SP_FX) at cycle 0 and rt=3 via pipe1 (SP_FX) at cycle 1;
  - cycle 3: pipe1 stage 2 value chosen over pipe0 stage 3.
  - Same stage in both pipes: pipe1 value chosen.
- Flush:
  - rt=4 issued at cycle 0 (BYTE), flush at cycle 1 → entry cleared, no stall on ra=4 afterwards, fw_data=src_data.
  - Entry at stage 4 during flush survives and forwards.
- Retirement: rt=8 SP_FX issued; at cycle DEPTH+1 → no hit, fw_data=src_data.
